// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the divider arbiter: FSM encoding, data width,
// divide-by-zero quotient and the round-robin pointer advance helper.
package div_arbiter_pkg;

   localparam int DATA_W = 32;
   localparam int ID_W   = 3;
   localparam logic [DATA_W-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_RESP  = 3'd4
   } state_e;

   function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id, input int nreq);
      if (int'(id) >= nreq - 1) begin
         return {ID_W{1'b0}};
      end else begin
         return id + ID_W'(1);
      end
   endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Request/response bundle between the requesters (master) and the arbiter (slave).
interface div_arbiter_if #(parameter int NREQ = 2);

   logic [NREQ-1:0]                          req_valid;
   logic [NREQ-1:0]                          req_ready;
   logic [div_arbiter_pkg::DATA_W*NREQ-1:0] req_x;
   logic [div_arbiter_pkg::DATA_W*NREQ-1:0] req_y;
   logic [NREQ-1:0]                          req_u;
   logic [NREQ-1:0]                          resp_valid;
   logic [NREQ-1:0]                          resp_ready;
   logic [div_arbiter_pkg::DATA_W-1:0]      resp_quot;
   logic [div_arbiter_pkg::DATA_W-1:0]      resp_rem;
   logic                                     resp_err;

   modport master (
      output req_valid, req_x, req_y, req_u, resp_ready,
      input  req_ready, resp_valid, resp_quot, resp_rem, resp_err
   );

   modport slave (
      input  req_valid, req_x, req_y, req_u, resp_ready,
      output req_ready, resp_valid, resp_quot, resp_rem, resp_err
   );

endinterface

// File: rtl/div_arbiter_rr_grant.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module div_arbiter_rr_grant
   import div_arbiter_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            any
);

   logic [2*NREQ-1:0] rot_s;
   int                sum_s;

   assign rot_s = {req, req} >> ptr;

   always_comb begin
      gnt_id = '0;
      any    = 1'b0;
      sum_s  = 0;
      for (int k = 0; k < NREQ; k++) begin
         if (!any && rot_s[k]) begin
            any   = 1'b1;
            sum_s = int'(ptr) + k;
            if (sum_s >= NREQ) begin
               sum_s = sum_s - NREQ;
            end else begin
               sum_s = sum_s;
            end
            gnt_id = ID_W'(sum_s);
         end else begin
            any = any;
         end
      end
      gnt = any ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_id) : '0;
   end

endmodule

// File: rtl/divider.sv
// Shared 32-bit sequential divider: one load edge plus 32 restoring steps while run=1;
// the iteration counter only clears on an edge with run=0 (no reset input).
module divider (
   input  logic        clk,
   input  logic        run,
   input  logic        u,
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic        stall,
   output logic [31:0] quot,
   output logic [31:0] rem
);

   localparam logic [5:0] LAST_CNT = 6'd33;

   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] q_q, q_d, r_q, r_d;
   logic        neg_q, neg_d;
   logic [32:0] trial_s, diff_s;
   logic        rem_nz_s;

   assign trial_s  = {r_q, q_q[31]};
   assign diff_s   = trial_s - {1'b0, y};
   assign rem_nz_s = |r_q;

   always_comb begin
      cnt_d = cnt_q;
      q_d   = q_q;
      r_d   = r_q;
      neg_d = neg_q;
      if (!run) begin
         cnt_d = 6'd0;
      end else if (cnt_q == 6'd0) begin
         // Negative signed dividends are divided by magnitude and fixed up on output.
         cnt_d = 6'd1;
         neg_d = u & x[31];
         q_d   = (u & x[31]) ? (32'd0 - x) : x;
         r_d   = 32'd0;
      end else if (cnt_q != LAST_CNT) begin
         cnt_d = cnt_q + 6'd1;
         if (!diff_s[32]) begin
            r_d = diff_s[31:0];
            q_d = {q_q[30:0], 1'b1};
         end else begin
            r_d = trial_s[31:0];
            q_d = {q_q[30:0], 1'b0};
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
      r_q   <= r_d;
      neg_q <= neg_d;
   end

   // Floored correction: -a = -(q*y + r) becomes quot = -q-1 = ~q, rem = y - r when r != 0.
   assign stall = run & (cnt_q != LAST_CNT);
   assign quot  = neg_q ? (rem_nz_s ? ~q_q : (32'd0 - q_q)) : q_q;
   assign rem   = (neg_q & rem_nz_s) ? (y - r_q) : r_q;

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sharing of one sequential divider among NREQ requesters, with operand
// latching, run/stall sequencing, divide-by-zero bypass and per-requester responses.
module div_arbiter
   import div_arbiter_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic          clk,
   input  logic          rst,
   div_arbiter_if.slave  bus
);

   state_e              state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d, id_q, id_d;
   logic [DATA_W-1:0]   x_q, x_d, y_q, y_d, quot_q, quot_d, rem_q, rem_d;
   logic                u_q, u_d, err_q, err_d;
   logic [NREQ-1:0]     resp_valid_q, resp_valid_d;

   logic [NREQ-1:0]     gnt_s, id_sel_s;
   logic [ID_W-1:0]     gnt_id_s;
   logic                gnt_any_s, resp_take_s;
   logic [DATA_W-1:0]   sel_x_s, sel_y_s, div_quot_s, div_rem_s;
   logic                sel_u_s, run_s, stall_s;

   div_arbiter_rr_grant #(.NREQ(NREQ)) u_rr (
      .req    (bus.req_valid),
      .ptr    (ptr_q),
      .gnt    (gnt_s),
      .gnt_id (gnt_id_s),
      .any    (gnt_any_s)
   );

   // Divider only ever sees the latched operands, and runs only in ST_RUN.
   divider u_div (
      .clk   (clk),
      .run   (run_s),
      .u     (u_q),
      .x     (x_q),
      .y     (y_q),
      .stall (stall_s),
      .quot  (div_quot_s),
      .rem   (div_rem_s)
   );

   assign run_s       = (state_q == ST_RUN);
   assign id_sel_s    = {{(NREQ-1){1'b0}}, 1'b1} << id_q;
   assign resp_take_s = |(bus.resp_ready & resp_valid_q);

   always_comb begin
      sel_x_s = '0;
      sel_y_s = '0;
      sel_u_s = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_id_s == ID_W'(k)) begin
            sel_x_s = bus.req_x[k*DATA_W +: DATA_W];
            sel_y_s = bus.req_y[k*DATA_W +: DATA_W];
            sel_u_s = bus.req_u[k];
         end else begin
            sel_u_s = sel_u_s;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      id_d         = id_q;
      x_d          = x_q;
      y_d          = y_q;
      u_d          = u_q;
      quot_d       = quot_q;
      rem_d        = rem_q;
      err_d        = err_q;
      resp_valid_d = resp_valid_q;
      case (state_q)
         ST_INIT: state_d = ST_IDLE;
         ST_IDLE: begin
            if (gnt_any_s) begin
               x_d   = sel_x_s;
               y_d   = sel_y_s;
               u_d   = sel_u_s;
               id_d  = gnt_id_s;
               ptr_d = rr_next(gnt_id_s, NREQ);
               if (sel_y_s == '0) begin
                  state_d = ST_RESP;
                  quot_d  = DIV_ZERO_QUOT;
                  rem_d   = sel_x_s;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!stall_s) begin
               quot_d       = div_quot_s;
               rem_d        = div_rem_s;
               err_d        = 1'b0;
               resp_valid_d = id_sel_s;
               state_d      = ST_DRAIN;
            end else begin
               state_d = ST_RUN;
            end
         end
         // DRAIN's run=0 edge clears the divider counter while the response is offered.
         ST_DRAIN: begin
            if (resp_take_s) begin
               resp_valid_d = '0;
               state_d      = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_take_s) begin
               resp_valid_d = '0;
               state_d      = ST_IDLE;
            end else begin
               resp_valid_d = id_sel_s;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_INIT;
         ptr_q        <= '0;
         id_q         <= '0;
         x_q          <= '0;
         y_q          <= '0;
         u_q          <= 1'b0;
         quot_q       <= '0;
         rem_q        <= '0;
         err_q        <= 1'b0;
         resp_valid_q <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         id_q         <= id_d;
         x_q          <= x_d;
         y_q          <= y_d;
         u_q          <= u_d;
         quot_q       <= quot_d;
         rem_q        <= rem_d;
         err_q        <= err_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   assign bus.req_ready  = (state_q == ST_IDLE) ? gnt_s : '0;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_quot  = quot_q;
   assign bus.resp_rem   = rem_q;
   assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Randomized and directed bench for div_arbiter, checked against a transaction-level
// model (round-robin choice, floored arithmetic, latency and spacing rules).
module tb_div_arbiter;
   import div_arbiter_pkg::*;

   localparam int NREQ = 2;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   div_arbiter_if #(.NREQ(NREQ)) bus_if ();
   div_arbiter #(.NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus_if));

   int          n_checks = 0, n_errors = 0;
   bit          pend, pend_y0, resp_seen, idle_exp, last_y0;
   int          pend_id, acc_cyc, last_acc, exp_ptr;
   logic [31:0] exp_q, exp_r, seen_q, seen_r;
   logic        exp_e, seen_e;
   int          grants[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Reference arithmetic: floored signed division done with wide signed integers.
   task automatic model(input logic [31:0] x, input logic [31:0] y, input logic u,
                        output logic [31:0] q, output logic [31:0] r, output logic e);
      longint a, b, qq, rm;
      if (y == 32'd0) begin
         q = 32'hFFFF_FFFF; r = x; e = 1'b1;
      end else if (u && x[31]) begin
         a  = longint'($signed(x));
         b  = longint'({32'd0, y});
         qq = a / b;
         rm = a - qq * b;
         if (rm < 0) begin qq = qq - 1; rm = rm + b; end
         q = qq[31:0]; r = rm[31:0]; e = 1'b0;
      end else begin
         q = x / y; r = x % y; e = 1'b0;
      end
   endtask

   task automatic observe();
      logic [NREQ-1:0] rr, rv, exp_v, exp_rr;
      int g, lat;
      rr = bus_if.req_ready;
      rv = bus_if.resp_valid;
      if (pend) begin
         exp_v = NREQ'(1) << pend_id;
         lat   = pend_y0 ? 1 : 34;
         check("busy_no_grant", 64'(rr), 64'd0);
         if (rv != '0) begin
            check("resp_owner", 64'(rv), 64'(exp_v));
            if (!resp_seen) check("resp_latency", 64'(cyc - acc_cyc), 64'(lat));
            resp_seen = 1'b1;
            seen_q = bus_if.resp_quot; seen_r = bus_if.resp_rem; seen_e = bus_if.resp_err;
            check("resp_quot", 64'(seen_q), 64'(exp_q));
            check("resp_rem", 64'(seen_r), 64'(exp_r));
            check("resp_err", 64'(seen_e), 64'(exp_e));
            if (bus_if.resp_ready[pend_id]) begin
               pend = 1'b0;
               idle_exp = 1'b1;
            end
         end else if (resp_seen || (cyc - acc_cyc >= lat)) begin
            check("resp_missing", 64'(rv), 64'(exp_v));
         end
      end else begin
         check("idle_resp", 64'(rv), 64'd0);
         if (!idle_exp) begin
            check("init_no_grant", 64'(rr), 64'd0);
            idle_exp = 1'b1;
         end else begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
               if (g < 0 && bus_if.req_valid[(exp_ptr + k) % NREQ]) g = (exp_ptr + k) % NREQ;
            end
            exp_rr = (g < 0) ? '0 : (NREQ'(1) << g);
            check("grant", 64'(rr), 64'(exp_rr));
            if (g >= 0 && rr == exp_rr) begin
               pend = 1'b1; pend_id = g; resp_seen = 1'b0; acc_cyc = cyc + 1;
               model(bus_if.req_x[g*32 +: 32], bus_if.req_y[g*32 +: 32], bus_if.req_u[g],
                     exp_q, exp_r, exp_e);
               pend_y0 = exp_e;
               if (last_acc >= 0)
                  check("accept_spacing", 64'((acc_cyc - last_acc) >= (last_y0 ? 2 : 35)), 64'd1);
               last_acc = acc_cyc; last_y0 = pend_y0;
               exp_ptr = (g + 1) % NREQ;
               grants.push_back(g);
            end
         end
      end
      if (!pend || pend_y0 || rv != '0) check("run_low", 64'(dut.run_s), 64'd0);
   endtask

   task automatic step();
      #1;
      observe();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int id, input logic v, input logic [31:0] x,
                          input logic [31:0] y, input logic u);
      bus_if.req_valid[id]      = v;
      bus_if.req_x[id*32 +: 32] = x;
      bus_if.req_y[id*32 +: 32] = y;
      bus_if.req_u[id]          = u;
   endtask

   task automatic single(input int id, input logic [31:0] x, input logic [31:0] y,
                         input logic u, input int hold);
      set_req(id, 1'b1, x, y, u);
      bus_if.resp_ready[id] = (hold == 0);
      for (int i = 0; i < 60 && !pend; i++) step();
      check("accepted", 64'(pend), 64'd1);
      bus_if.req_valid[id] = 1'b0;
      for (int i = 0; i < 60 && !resp_seen; i++) step();
      check("resp_seen", 64'(resp_seen), 64'd1);
      for (int i = 0; i < hold; i++) step();
      bus_if.resp_ready[id] = 1'b1;
      for (int i = 0; i < 5 && pend; i++) step();
      check("handshake", 64'(pend), 64'd0);
      bus_if.resp_ready[id] = 1'b0;
   endtask

   task automatic model_reset();
      pend = 1'b0; idle_exp = 1'b0; exp_ptr = 0; last_acc = -1; resp_seen = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check("rst_req_ready", 64'(bus_if.req_ready), 64'd0);
      check("rst_resp_valid", 64'(bus_if.resp_valid), 64'd0);
      check("rst_quot", 64'(bus_if.resp_quot), 64'd0);
      check("rst_rem", 64'(bus_if.resp_rem), 64'd0);
      check("rst_err", 64'(bus_if.resp_err), 64'd0);
      check("rst_run", 64'(dut.run_s), 64'd0);
   endtask

   initial begin
      logic [31:0] rx, ry;
      rst = 1'b0;
      bus_if.req_valid = '0; bus_if.req_x = '0; bus_if.req_y = '0;
      bus_if.req_u = '0; bus_if.resp_ready = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst = 1'b1;

      // Basic unsigned, signed floored, unsigned view of a negative pattern, divide-by-zero.
      single(0, 32'd100, 32'd7, 1'b0, 0);
      check("t1_quot", 64'(seen_q), 64'd14);
      check("t1_rem", 64'(seen_r), 64'd2);
      single(1, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
      check("t2s_quot", 64'(seen_q), 64'hFFFF_FFFC);
      check("t2s_rem", 64'(seen_r), 64'd1);
      single(0, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
      check("t2u_quot", 64'(seen_q), 64'h7FFF_FFFC);
      single(0, 32'd5, 32'd0, 1'b0, 0);
      check("t3_quot", 64'(seen_q), 64'hFFFF_FFFF);
      check("t3_rem", 64'(seen_r), 64'd5);
      check("t3_err", 64'(seen_e), 64'd1);

      // Both requesters held valid: grants must alternate.
      grants.delete();
      set_req(0, 1'b1, 32'd1234567, 32'd89, 1'b0);
      set_req(1, 1'b1, 32'h8000_0000, 32'd3, 1'b1);
      bus_if.resp_ready = '1;
      for (int i = 0; i < 400 && grants.size() < 4; i++) step();
      check("t4_grants", 64'(grants.size() >= 4), 64'd1);
      for (int i = 1; i < grants.size(); i++) check("t4_alternate", 64'(grants[i]), 64'(grants[i-1] ^ 1));
      bus_if.req_valid = '0;
      for (int i = 0; i < 60 && pend; i++) step();
      bus_if.resp_ready = '0;
      step();

      // Backpressure for 50 cycles with another requester waiting.
      set_req(0, 1'b1, 32'd1000, 32'd9, 1'b0);
      for (int i = 0; i < 60 && !pend; i++) step();
      bus_if.req_valid[0] = 1'b0;
      for (int i = 0; i < 60 && !resp_seen; i++) step();
      set_req(1, 1'b1, 32'd77, 32'd5, 1'b0);
      for (int i = 0; i < 50; i++) step();
      bus_if.resp_ready[0] = 1'b1;
      step();
      bus_if.resp_ready[0] = 1'b0;
      step();
      check("t5_next_accept", 64'(pend), 64'd1);
      check("t5_next_id", 64'(pend_id), 64'd1);
      bus_if.req_valid[1] = 1'b0;
      bus_if.resp_ready[1] = 1'b1;
      for (int i = 0; i < 60 && pend; i++) step();
      bus_if.resp_ready[1] = 1'b0;

      // Reset in the middle of a division.
      set_req(0, 1'b1, 32'd1000, 32'd3, 1'b0);
      for (int i = 0; i < 60 && !pend; i++) step();
      bus_if.req_valid[0] = 1'b0;
      for (int i = 0; i < 10; i++) step();
      rst = 1'b0;
      #1;
      check_reset_outputs();
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b1;
      single(0, 32'd9, 32'd3, 1'b0, 0);
      check("t6_quot", 64'(seen_q), 64'd3);
      check("t6_rem", 64'(seen_r), 64'd0);

      // Random traffic, random backpressure, occasional zero divisors and withdrawn requests.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               rx = $urandom;
               ry = ($urandom_range(0, 7) == 0) ? 32'd0 :
                    ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 20)) : $urandom;
               set_req(i, 1'($urandom_range(0, 1)), rx, ry, 1'($urandom_range(0, 1)));
            end
         end
         bus_if.resp_ready = NREQ'($urandom);
         step();
      end
      bus_if.req_valid = '0;
      bus_if.resp_ready = '1;
      for (int i = 0; i < 60 && pend; i++) step();
      check("final_idle", 64'(pend), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
